secded_pipe_dec: RTL and testbench

- Parametrised, pipelined single-error-correct / double-error-detect (SEC-DED) Hamming decoder.
- Sequential successor to the 16-bit combinational SEC-DED error-correction benchmark used in the low-power flow.
- Generalises data width, adds a two-stage registered pipeline with valid/ready handshake, and adds saturating error statistics.
- Sits between a storage or link read port and its consumer.

---
 rtl/secded_pkg.sv | 35 +++
 rtl/secded_chkgen.sv | 21 ++
 rtl/secded_pipe_dec.sv | 123 ++++++++++++
 tb/tb_secded_pipe_dec.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared helpers for the SEC-DED decoder: check-width sizing, codeword
// position mapping and the error classification enum.
package secded_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SBE, ERR_DBE} err_kind_e;

  // Hamming bits r (smallest with 2^r >= data_w + r + 1) plus overall parity.
  function automatic int chk_w(input int data_w);
    int r;
    r = 0;
    for (int k = 1; k <= 8; k++)
      if (r == 0 && (1 << k) >= data_w + k + 1) r = k;
    return r + 1;
  endfunction

  function automatic logic pos_is_data(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) != 0);
  endfunction

  // Data bits fill non-power-of-two positions in ascending order.
  function automatic int data_pos(input int idx);
    int n;
    int res;
    n = 0;
    res = 0;
    for (int p = 3; p <= 72; p++) begin
      if (pos_is_data(p)) begin
        if (n == idx && res == 0) res = p;
        n++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_chkgen.sv
// Combinational SEC-DED encoder: Hamming checks in the low bits, even
// overall parity (over data and Hamming checks) in the MSB.
module secded_chkgen
  import secded_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int CHK_W = chk_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CHK_W-1:0]  chk
);

  always_comb begin
    chk = '0;
    for (int j = 0; j < DATA_W; j++)
      for (int i = 0; i < CHK_W - 1; i++)
        if (((data_pos(j) >> i) & 1) != 0) chk[i] = chk[i] ^ data[j];
    chk[CHK_W-1] = ^{data, chk[CHK_W-2:0]};
  end

endmodule

// File: rtl/secded_pipe_dec.sv
// Two-stage pipelined SEC-DED decoder with valid/ready handshake.
// Optional saturating error counters under `SECDED_ERR_CNT_EN.
module secded_pipe_dec
  import secded_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  localparam int CHK_W = chk_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sbe,
  output logic              out_dbe,
  output logic [CHK_W-1:0]  out_syn,
  input  logic              cnt_clr
`ifdef SECDED_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt
`endif
);

  localparam int HW = CHK_W - 1;
  localparam logic [HW-1:0] MAXPOS = HW'(DATA_W + CHK_W - 1);

  logic [CHK_W-1:0]  gen_chk;
  logic [HW-1:0]     syn_p0;
  logic              par_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [HW-1:0]     syn_p1;
  logic              par_p1;
  logic              s2_load;
  logic [DATA_W-1:0] cor_data;
  err_kind_e         kind;

  secded_chkgen #(.DATA_W(DATA_W)) u_chkgen (
    .data (in_data),
    .chk  (gen_chk)
  );

  assign syn_p0   = gen_chk[HW-1:0] ^ in_chk[HW-1:0];
  // Parity over the received word equals regenerated parity folded with the syndrome.
  assign par_p0   = gen_chk[HW] ^ in_chk[HW] ^ (^syn_p0);
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_load;

  // ---- S1: received data, syndrome, parity mismatch ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_data;
      syn_p1  <= syn_p0;
      par_p1  <= par_p0;
    end
  end

  always_comb begin
    kind     = ERR_NONE;
    cor_data = data_p1;
    if (syn_p1 == '0) begin
      kind = par_p1 ? ERR_SBE : ERR_NONE;
    end else if (!par_p1 || syn_p1 > MAXPOS) begin
      kind = ERR_DBE;
    end else begin
      kind = ERR_SBE;
      for (int j = 0; j < DATA_W; j++)
        if (syn_p1 == HW'(data_pos(j))) cor_data[j] = ~data_p1[j];
    end
  end

  // ---- S2: corrected data, flags, syndrome ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sbe   <= 1'b0;
      out_dbe   <= 1'b0;
      out_syn   <= '0;
    end else if (s2_load) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= cor_data;
        out_sbe  <= (kind == ERR_SBE);
        out_dbe  <= (kind == ERR_DBE);
        out_syn  <= {par_p1, syn_p1};
      end
    end
  end

`ifdef SECDED_ERR_CNT_EN
  logic fire;
  assign fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else if (cnt_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (fire && out_sbe && sbe_cnt != '1) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (fire && out_dbe && dbe_cnt != '1) dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_secded_pipe_dec.sv
// Directed bench for secded_pipe_dec (DATA_W=16, CNT_W=2).
module tb_secded_pipe_dec;

  localparam int DW = 16;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_chk;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sbe;
  logic          out_dbe;
  logic [CW-1:0] out_syn;
  logic          cnt_clr;
`ifdef SECDED_ERR_CNT_EN
  logic [1:0]    sbe_cnt;
  logic [1:0]    dbe_cnt;
`endif

  logic [DW-1:0] ref_d;
  logic [CW-1:0] ref_c;

  int checks = 0;
  int failures = 0;

  secded_pipe_dec #(.DATA_W(DW), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chk    (in_chk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sbe   (out_sbe),
    .out_dbe   (out_dbe),
    .out_syn   (out_syn),
    .cnt_clr   (cnt_clr)
`ifdef SECDED_ERR_CNT_EN
    ,
    .sbe_cnt   (sbe_cnt),
    .dbe_cnt   (dbe_cnt)
`endif
  );

  secded_chkgen #(.DATA_W(DW)) u_ref (.data(ref_d), .chk(ref_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] df;
    logic [CW-1:0] cf;
    logic [DW-1:0] ed;
    logic          es;
    logic          ee;
    logic [CW-1:0] esyn;
  } vec_t;

  vec_t tv[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic encode(input logic [DW-1:0] d, output logic [CW-1:0] c);
    ref_d = d;
    #1;
    c = ref_c;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word for a single cycle; called just after a rising edge.
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_chk   = c;
    cyc(1);
    in_valid = 1'b0;
  endtask

  logic [CW-1:0] c;
  logic [DW-1:0] wd[4];
  logic [CW-1:0] wc[4];
  logic [DW-1:0] gd[4];
  int acc;
  int got;

  initial begin
    tv[0]  = '{16'hA5C3, 16'h0000, 6'h00, 16'hA5C3, 1'b0, 1'b0, 6'h00};
    tv[1]  = '{16'hA5C3, 16'h0020, 6'h00, 16'hA5C3, 1'b1, 1'b0, 6'h2A};
    tv[2]  = '{16'hA5C3, 16'h0201, 6'h00, 16'hA7C2, 1'b0, 1'b1, 6'h0D};
    tv[3]  = '{16'hA5C3, 16'h0000, 6'h20, 16'hA5C3, 1'b1, 1'b0, 6'h20};
    tv[4]  = '{16'hA5C3, 16'h0000, 6'h04, 16'hA5C3, 1'b1, 1'b0, 6'h24};
    tv[5]  = '{16'hA5C3, 16'h8000, 6'h00, 16'hA5C3, 1'b1, 1'b0, 6'h35};
    tv[6]  = '{16'hA5C3, 16'h8011, 6'h00, 16'h25D2, 1'b0, 1'b1, 6'h3F};
    tv[7]  = '{16'hA5C3, 16'h0000, 6'h03, 16'hA5C3, 1'b0, 1'b1, 6'h03};
    tv[8]  = '{16'hFFFF, 16'h0080, 6'h00, 16'hFFFF, 1'b1, 1'b0, 6'h2C};
    tv[9]  = '{16'h1234, 16'h0400, 6'h00, 16'h1234, 1'b1, 1'b0, 6'h2F};
    tv[10] = '{16'h0000, 16'h0002, 6'h20, 16'h0002, 1'b0, 1'b1, 6'h05};
    tv[11] = '{16'h0000, 16'h0000, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00};
    tv[12] = '{16'h5A5A, 16'h0000, 6'h10, 16'h5A5A, 1'b1, 1'b0, 6'h30};
    for (int k = 0; k < 4; k++) begin
      wd[k] = DW'(k + 1);
      encode(wd[k], wc[k]);
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    encode(16'hA5C3, c);
    check("ref_enc_a5c3", 32'(c), 32'h05);
    cyc(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_syn", 32'(out_syn), 0);
    check("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    cyc(1);
    check("idle_in_ready", 32'(in_ready), 1);

    // Single-word vectors with exact two-cycle latency.
    for (int i = 0; i < 13; i++) begin
      encode(tv[i].d, c);
      send(tv[i].d ^ tv[i].df, c ^ tv[i].cf);
      check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 0);
      cyc(1);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d_data", i), 32'(out_data), 32'(tv[i].ed));
      check($sformatf("v%0d_sbe", i), 32'(out_sbe), 32'(tv[i].es));
      check($sformatf("v%0d_dbe", i), 32'(out_dbe), 32'(tv[i].ee));
      check($sformatf("v%0d_syn", i), 32'(out_syn), 32'(tv[i].esyn));
      cyc(2);
    end

    // Backpressure: four words against a stalled consumer.
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin in_data = wd[acc]; in_chk = wc[acc]; end
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("stall_accepted", 32'(acc), 2);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_hold_valid", 32'(out_valid), 1);
    check("stall_hold_data", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin in_data = wd[acc]; in_chk = wc[acc]; end
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        if (got < 4) gd[got] = out_data;
        got++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("release_count", 32'(got), 4);
    for (int k = 0; k < 4; k++)
      if (k < got) check($sformatf("release_order%0d", k), 32'(gd[k]), 32'(k + 1));
    cyc(3);
    check("drained_valid", 32'(out_valid), 0);

`ifdef SECDED_ERR_CNT_EN
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    check("clr_sbe_cnt", 32'(sbe_cnt), 0);
    check("clr_dbe_cnt", 32'(dbe_cnt), 0);
    encode(16'hA5C3, c);
    send(16'hA5C3 ^ 16'h0201, c);
    cyc(3);
    check("dbe_cnt_one", 32'(dbe_cnt), 1);
    check("dbe_sbe_cnt_zero", 32'(sbe_cnt), 0);

    // Five SBE words saturate a 2-bit counter.
    in_valid = 1'b1;
    in_data  = 16'hA5C3 ^ 16'h0020;
    in_chk   = c;
    cyc(5);
    in_valid = 1'b0;
    cyc(3);
    check("sbe_cnt_sat", 32'(sbe_cnt), 3);
    send(16'hA5C3 ^ 16'h0020, c);
    cyc(1);
    check("sbe6_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    check("sbe_cnt_clr_prio", 32'(sbe_cnt), 0);
    send(16'hA5C3 ^ 16'h0020, c);
    cyc(3);
    check("sbe_cnt_after_clr", 32'(sbe_cnt), 1);
`endif

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = wd[0]; in_chk = wc[0];
    cyc(1);
    in_data = wd[1]; in_chk = wc[1];
    cyc(1);
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_data", 32'(out_data), 0);
`ifdef SECDED_ERR_CNT_EN
    check("async_rst_sbe_cnt", 32'(sbe_cnt), 0);
`endif
    cyc(2);
    rst = 1'b0;
    out_ready = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    cyc(1);
    check("post_rst_no_ghost", 32'(out_valid), 0);
    send(wd[2], wc[2]);
    check("post_rst_lat1", 32'(out_valid), 0);
    cyc(1);
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", 32'(out_data), 32'h3);
    check("post_rst_flags", 32'({out_sbe, out_dbe}), 0);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
